// File: rtl/conv_input_feeder.sv
// conv_input_feeder: stages processing-system words in a FIFO and feeds KERNEL_LEN-word windows to the convolution accelerator
// Optional WAIT timeout with sticky err is enabled by defining FEEDER_TIMEOUT_EN.
module conv_input_feeder #(
   parameter int DATA_W     = 16,
   parameter int KERNEL_LEN = 9,
   parameter int DEPTH      = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] dataInput,
   output logic              wr_en,
   input  logic              FULL,
   output logic              cStart,
   input  logic              cReady,
   output logic              busy,
   output logic [15:0]       win_count,
   output logic              err
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam int CW = $clog2(KERNEL_LEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [NW-1:0]     r_count;
   logic [CW-1:0]     r_load_cnt;
   logic [DATA_W-1:0] r_data;
   logic              r_wr_en;
   logic              r_cstart;
   logic [15:0]       r_win_cnt;
   logic              w_push;
   logic              w_pop;
   logic              w_last;
   logic              w_tmo;

   // occupancy never exceeds DEPTH (a power of two), so the count MSB alone marks full
   assign s_ready = ~r_count[AW];
   assign w_push  = s_valid & s_ready;
   assign w_pop   = (r_state == LOAD) & (r_count != '0) & ~FULL;
   assign w_last  = (r_load_cnt == CW'(KERNEL_LEN - 1));

`ifdef FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tmo;
   logic          r_err;

   assign w_tmo = (r_state == WAIT) & ~cReady & (r_tmo == TW'(TIMEOUT - 1));
   assign err   = r_err;

   // cycles spent in WAIT; cleared whenever the FSM is elsewhere
   always_ff @(posedge Clk) begin
      if (!Rst || r_state != WAIT) r_tmo <= '0;
      else r_tmo <= r_tmo + 1'b1;
   end

   // sticky timeout flag, only cleared by reset
   always_ff @(posedge Clk) begin
      if (!Rst) r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
   end
`else
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif

   // staging storage; contents need no reset because the pointers define validity
   always_ff @(posedge Clk) begin
      if (w_push) r_mem[r_wptr] <= s_data;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + NW'(w_push) - NW'(w_pop);
      end
   end

   // popped word is presented to the accelerator with a one-cycle write strobe
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_data  <= '0;
         r_wr_en <= 1'b0;
      end else begin
         r_wr_en <= w_pop;
         if (w_pop) r_data <= r_mem[r_rptr];
      end
   end

   // window sequencing: load KERNEL_LEN words, pulse start, wait for completion
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_state    <= IDLE;
         r_load_cnt <= '0;
         r_cstart   <= 1'b0;
         r_win_cnt  <= '0;
      end else begin
         r_cstart <= (r_state == START);
         case (r_state)
            IDLE: begin
               if (r_count != '0) begin
                  r_state    <= LOAD;
                  r_load_cnt <= '0;
               end
            end
            LOAD: begin
               if (w_pop) begin
                  if (w_last) r_state <= START;
                  else r_load_cnt <= r_load_cnt + 1'b1;
               end
            end
            START: r_state <= WAIT;
            WAIT: begin
               if (cReady) begin
                  r_state   <= IDLE;
                  r_win_cnt <= r_win_cnt + 16'd1;
               end else if (w_tmo) begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign dataInput = r_data;
   assign wr_en     = r_wr_en;
   assign cStart    = r_cstart;
   assign busy      = (r_state != IDLE);
   assign win_count = r_win_cnt;
endmodule

// File: tb/tb_conv_input_feeder.sv
// tb_conv_input_feeder: table-driven windows plus directed sequences for backpressure, reset, timeout and wrap
module tb_conv_input_feeder;
   localparam int KL = 9;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] dataInput;
   logic        wr_en;
   logic        FULL = 1'b0;
   logic        cStart;
   logic        cReady = 1'b0;
   logic        busy;
   logic [15:0] win_count;
   logic        err;

   int passed = 0;
   int total = 0;

   always #5 Clk = ~Clk;

   conv_input_feeder #(.DATA_W(16), .KERNEL_LEN(KL), .DEPTH(16), .TIMEOUT(8)) dut (
      .Clk(Clk), .Rst(Rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dataInput(dataInput), .wr_en(wr_en), .FULL(FULL), .cStart(cStart), .cReady(cReady),
      .busy(busy), .win_count(win_count), .err(err)
   );

   typedef struct {
      logic [15:0] base;
      int          stall_at;
      int          stall_len;
      int          rdy_dly;
      int          exp_win;
      int          exp_span;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // pushes KL words from base, optionally holds FULL for stall_len edges after the stall_at-th write,
   // pulses cReady rdy_dly cycles after cStart (never if negative, returning at cStart instead)
   task automatic run_window(input logic [15:0] base, input int stall_at, input int stall_len,
                             input int rdy_dly, output int nw, output int ncs, output int span,
                             output bit ok, output bit fin);
      int pushed = 0;
      int first = -1;
      int stall_left = 0;
      int rdy = -1;
      nw = 0; ncs = 0; span = -1; ok = 1'b1; fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         s_valid = (pushed < KL);
         s_data = base + 16'(pushed);
         if (s_valid && s_ready) pushed++;
         FULL = (stall_left > 0);
         cReady = (rdy == 0);
         @(negedge Clk);
         if (stall_left > 0) stall_left--;
         if (cReady) fin = 1'b1;
         if (wr_en) begin
            if (dataInput !== base + 16'(nw)) ok = 1'b0;
            nw++;
            if (nw == 1) first = cyc;
            if (nw == stall_at) stall_left = stall_len;
         end
         if (cStart) begin
            ncs++;
            span = cyc - first;
            if (rdy_dly < 0) fin = 1'b1;
            else rdy = rdy_dly;
         end else if (rdy > 0) rdy--;
      end
      s_valid = 1'b0;
      FULL = 1'b0;
      cReady = 1'b0;
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      int nw, ncs, span, got, cs, seen, pushed, stray;
      bit ok, fin;

      vecs[0] = '{16'h0001, 0, 0, 5, 1, 9};
      vecs[1] = '{16'h0100, 3, 4, 0, 2, 13};
      vecs[2] = '{16'hA000, 1, 2, 2, 3, 11};
      vecs[3] = '{16'hFFF8, 8, 1, 1, 4, 10};

      @(negedge Clk);
      @(negedge Clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_cStart", cStart, 0);
      chk("rst_dataInput", dataInput, 0);
      chk("rst_busy", busy, 0);
      chk("rst_win_count", win_count, 0);
      chk("rst_err", err, 0);
      Rst = 1'b1;

      cReady = 1'b1;
      @(negedge Clk);
      cReady = 1'b0;
      @(negedge Clk);
      chk("idle_cready_win", win_count, 0);
      chk("idle_cready_busy", busy, 0);

      for (int i = 0; i < 4; i++) begin
         run_window(vecs[i].base, vecs[i].stall_at, vecs[i].stall_len, vecs[i].rdy_dly, nw, ncs, span, ok, fin);
         chk($sformatf("v%0d_done", i), fin, 1);
         chk($sformatf("v%0d_writes", i), nw, KL);
         chk($sformatf("v%0d_order", i), ok, 1);
         chk($sformatf("v%0d_cstarts", i), ncs, 1);
         chk($sformatf("v%0d_span", i), span, vecs[i].exp_span);
         chk($sformatf("v%0d_win", i), win_count, vecs[i].exp_win);
         chk($sformatf("v%0d_busy", i), busy, 0);
      end

      FULL = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_data = 16'h0200 + 16'(i);
         @(negedge Clk);
      end
      chk("fifo_full_ready", s_ready, 0);
      s_data = 16'h0300;
      @(negedge Clk);
      s_valid = 1'b0;
      chk("fifo_17th_ready", s_ready, 0);
      chk("fifo_full_nowr", wr_en, 0);
      chk("fifo_full_busy", busy, 1);
      FULL = 1'b0;
      got = 0; cs = 0; ok = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge Clk);
         cReady = 1'b0;
         if (wr_en) begin
            if (dataInput !== 16'h0200 + 16'(got)) ok = 1'b0;
            got++;
         end
         if (cStart) begin
            cs++;
            cReady = 1'b1;
         end
      end
      cReady = 1'b0;
      chk("drain_count", got, 16);
      chk("drain_order", ok, 1);
      chk("drain_cstarts", cs, 1);
      chk("drain_ready", s_ready, 1);
      chk("drain_win", win_count, 5);
      do_reset();

      pushed = 0; seen = 0;
      for (int c = 0; c < 40 && seen < 5; c++) begin
         s_valid = (pushed < KL);
         s_data = 16'h0400 + 16'(pushed);
         if (s_valid && s_ready) pushed++;
         @(negedge Clk);
         if (wr_en) seen++;
      end
      chk("midrst_seen", seen, 5);
      Rst = 1'b0;
      s_valid = 1'b0;
      @(negedge Clk);
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_cStart", cStart, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", s_ready, 1);
      chk("midrst_data", dataInput, 0);
      chk("midrst_win", win_count, 0);
      chk("midrst_err", err, 0);
      Rst = 1'b1;
      stray = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge Clk);
         if (wr_en || cStart || busy) stray++;
      end
      chk("midrst_no_stale", stray, 0);
      run_window(16'h0500, 0, 0, 3, nw, ncs, span, ok, fin);
      chk("post_rst_done", fin, 1);
      chk("post_rst_writes", nw, KL);
      chk("post_rst_order", ok, 1);
      chk("post_rst_cstarts", ncs, 1);
      chk("post_rst_win", win_count, 1);

      run_window(16'h0600, 0, 0, -1, nw, ncs, span, ok, fin);
      chk("tmo_cstart_seen", fin, 1);
      repeat (7) @(negedge Clk);
      chk("tmo_err_early", err, 0);
      chk("tmo_busy_early", busy, 1);
      @(negedge Clk);
`ifdef FEEDER_TIMEOUT_EN
      chk("tmo_err", err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_win", win_count, 1);
`else
      chk("notmo_err", err, 0);
      repeat (20) @(negedge Clk);
      chk("notmo_busy", busy, 1);
      chk("notmo_win", win_count, 1);
`endif
      do_reset();

      force dut.r_win_cnt = 16'hFFFF;
      @(negedge Clk);
      release dut.r_win_cnt;
      @(negedge Clk);
      chk("wrap_preload", win_count, 16'hFFFF);
      run_window(16'h0700, 0, 0, 1, nw, ncs, span, ok, fin);
      chk("wrap_done", fin, 1);
      chk("wrap_win", win_count, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
